// File: rtl/bmp_pkg.sv
// bmp_pkg: shared definitions for the BMP command sequencer.
//   - register window offsets relative to the block base address
//   - command entry layout (26 bits) as a packed struct
//   - status word bit positions
//   - sequencer FSM state encoding
package bmp_pkg;

    // Register window offsets
    localparam logic [15:0] XLOC_OFS = 16'd0;
    localparam logic [15:0] YLOC_OFS = 16'd1;
    localparam logic [15:0] CMD_OFS  = 16'd2;
    localparam logic [15:0] STAT_OFS = 16'd3;

    // Command entry: {x[25:16], y[15:7], rem[6], idx[5:1], img[0]}
    localparam int unsigned CMD_W   = 26;
    localparam int unsigned CMD_IMG = 0;
    localparam int unsigned CMD_IDX = 1;
    localparam int unsigned CMD_REM = 6;
    localparam int unsigned CMD_Y   = 7;
    localparam int unsigned CMD_X   = 16;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       rem;
        logic [4:0] idx;
        logic       img;
    } cmd_t;

    // Status word bit positions
    localparam int unsigned STAT_OVF  = 15;
    localparam int unsigned STAT_TMO  = 14;
    localparam int unsigned STAT_BUSY = 13;
    localparam int unsigned STAT_CLR  = 12;

    typedef enum logic [1:0] {
        StWaitClr  = 2'd0,
        StIdle     = 2'd1,
        StIssue    = 2'd2,
        StWaitDone = 2'd3
    } seq_state_t;

endpackage

// File: rtl/bmp_cmd_fifo.sv
// bmp_cmd_fifo: circular command FIFO, DEPTH entries of cmd_t.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers and count only)
//   push, din    enqueue request and data; dropped when full
//   pop          dequeue request; ignored when empty
//   dout         head entry (valid while !empty)
//   full, empty  derived from the pre-edge count
//   count        number of stored entries, log2(DEPTH)+1 bits
module bmp_cmd_fifo
    import bmp_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     din,
    input  logic                     pop,
    output cmd_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmp_cmd_sequencer.sv
// bmp_cmd_sequencer: CPU register window, command queue and issue FSM in front
// of the BMP/font placement engine. One queued command is issued per engine
// draw; the next issue waits for plc_done or a timeout.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bmp_sel, addr, databus CPU write strobe qualifier, address, write data
//   end_clear             video-memory clear finished (level)
//   plc_done              engine draw-finished pulse
//   xloc, yloc            location of the issued command
//   add_img/add_fnt/rem_img one-cycle issue strobes (exactly one per issue)
//   image_indx, fnt_indx  index of the issued command
//   status                {ovf, tmo, busy, clr_done, 8'b0, count[3:0]}
module bmp_cmd_sequencer
    import bmp_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [19:0] TIMEOUT   = 20'd800000,
    parameter logic [15:0] BASE_ADDR = 16'hC008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bmp_sel,
    input  logic [15:0] addr,
    input  logic [15:0] databus,
    input  logic        end_clear,
    input  logic        plc_done,
    output logic [9:0]  xloc,
    output logic [8:0]  yloc,
    output logic        add_img,
    output logic        add_fnt,
    output logic        rem_img,
    output logic [4:0]  image_indx,
    output logic [4:0]  fnt_indx,
    output logic [15:0] status
);

    localparam logic [19:0] TIMER_LAST = TIMEOUT - 20'd1;

    seq_state_t             state;
    logic [19:0]            timer;
    logic                   tmo;
    logic                   ovf;
    logic [9:0]             xstage;
    logic [8:0]             ystage;
    logic                   x_wr, y_wr, cmd_wr, stat_wr;
    logic                   fifo_pop, fifo_full, fifo_empty;
    cmd_t                   fifo_din, head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   unused_bits;

    assign x_wr    = bmp_sel && (addr == BASE_ADDR + XLOC_OFS);
    assign y_wr    = bmp_sel && (addr == BASE_ADDR + YLOC_OFS);
    assign cmd_wr  = bmp_sel && (addr == BASE_ADDR + CMD_OFS);
    assign stat_wr = bmp_sel && (addr == BASE_ADDR + STAT_OFS);

    assign unused_bits = ^databus[14:10];

    assign fifo_din = '{x: xstage, y: ystage, rem: databus[15], idx: databus[5:1],
                        img: databus[0]};
    assign fifo_pop = (state == StIdle) && !fifo_empty;

    bmp_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_wr),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Staging registers persist across commands; ovf records a dropped enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xstage <= '0;
            ystage <= '0;
            ovf    <= 1'b0;
        end else begin
            if (x_wr) begin
                xstage <= databus[9:0];
            end
            if (y_wr) begin
                ystage <= databus[8:0];
            end
            if (cmd_wr && fifo_full) begin
                ovf <= 1'b1;
            end else if (stat_wr && databus[15]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StWaitClr;
            timer      <= '0;
            tmo        <= 1'b0;
            xloc       <= '0;
            yloc       <= '0;
            image_indx <= '0;
            fnt_indx   <= '0;
            add_img    <= 1'b0;
            add_fnt    <= 1'b0;
            rem_img    <= 1'b0;
        end else begin
            // A timeout in the same cycle as a clear request wins (assigned later).
            if (stat_wr && databus[15]) begin
                tmo <= 1'b0;
            end
            unique case (state)
                StWaitClr: begin
                    if (end_clear) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (!fifo_empty) begin
                        state      <= StIssue;
                        xloc       <= head.x;
                        yloc       <= head.y;
                        image_indx <= head.idx;
                        fnt_indx   <= head.idx;
                        rem_img    <= head.rem;
                        add_img    <= !head.rem && head.img;
                        add_fnt    <= !head.rem && !head.img;
                    end
                end
                StIssue: begin
                    state   <= StWaitDone;
                    timer   <= '0;
                    add_img <= 1'b0;
                    add_fnt <= 1'b0;
                    rem_img <= 1'b0;
                end
                StWaitDone: begin
                    if (plc_done) begin
                        state <= StIdle;
                    end else if (timer == TIMER_LAST) begin
                        tmo   <= 1'b1;
                        state <= StIdle;
                    end else if (timer != '1) begin
                        timer <= timer + 20'd1;
                    end
                end
                default: state <= StWaitClr;
            endcase
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_OVF]  = ovf;
        status[STAT_TMO]  = tmo;
        status[STAT_BUSY] = (state != StIdle) || !fifo_empty;
        status[STAT_CLR]  = (state != StWaitClr);
        status[3:0]       = 4'(fifo_count);
    end

endmodule

// File: tb/tb_bmp_cmd_sequencer.sv
// tb_bmp_cmd_sequencer: directed bench for bmp_cmd_sequencer (DEPTH=8, TIMEOUT=16).
// A negedge monitor logs every issue strobe with its payload and cycle number.
module tb_bmp_cmd_sequencer;

    localparam logic [15:0] BASE = 16'hC008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bmp_sel;
    logic [15:0] addr;
    logic [15:0] databus;
    logic        end_clear;
    logic        plc_done;
    logic [9:0]  xloc;
    logic [8:0]  yloc;
    logic        add_img, add_fnt, rem_img;
    logic [4:0]  image_indx, fnt_indx;
    logic [15:0] status;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Strobe log: kind = {rem_img, add_img, add_fnt}
    logic [2:0] log_kind[$];
    logic [4:0] log_idx[$];
    logic [9:0] log_x[$];
    logic [8:0] log_y[$];
    int         log_cyc[$];
    int         wide_cnt    = 0;
    int         multi_cnt   = 0;
    int         overlap_cnt = 0;
    logic       prev_strobe = 1'b0;
    logic       outstanding = 1'b0;
    logic       chk_overlap = 1'b0;

    bmp_cmd_sequencer #(
        .DEPTH     (8),
        .TIMEOUT   (20'd16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bmp_sel    (bmp_sel),
        .addr       (addr),
        .databus    (databus),
        .end_clear  (end_clear),
        .plc_done   (plc_done),
        .xloc       (xloc),
        .yloc       (yloc),
        .add_img    (add_img),
        .add_fnt    (add_fnt),
        .rem_img    (rem_img),
        .image_indx (image_indx),
        .fnt_indx   (fnt_indx),
        .status     (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (add_img || add_fnt || rem_img) begin
            log_kind.push_back({rem_img, add_img, add_fnt});
            log_idx.push_back(image_indx);
            log_x.push_back(xloc);
            log_y.push_back(yloc);
            log_cyc.push_back(cyc);
            if (prev_strobe) wide_cnt <= wide_cnt + 1;
            if (int'(rem_img) + int'(add_img) + int'(add_fnt) != 1) multi_cnt <= multi_cnt + 1;
            if (chk_overlap && outstanding) overlap_cnt <= overlap_cnt + 1;
            outstanding <= 1'b1;
        end else if (plc_done) begin
            outstanding <= 1'b0;
        end
        prev_strobe <= add_img || add_fnt || rem_img;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [15:0] ofs, input logic [15:0] data);
        bmp_sel = 1'b1;
        addr    = BASE + ofs;
        databus = data;
        step(1);
        bmp_sel = 1'b0;
        addr    = '0;
        databus = '0;
    endtask

    task automatic pulse_done();
        plc_done = 1'b1;
        step(1);
        plc_done = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int b = budget;
        while (log_kind.size() < n && b > 0) begin
            step(1);
            b--;
        end
        check_eq(tag, log_kind.size(), n);
    endtask

    task automatic clear_log();
        log_kind.delete();
        log_idx.delete();
        log_x.delete();
        log_y.delete();
        log_cyc.delete();
    endtask

    initial begin
        int e;
        rst_n     = 1'b0;
        bmp_sel   = 1'b0;
        addr      = '0;
        databus   = '0;
        end_clear = 1'b0;
        plc_done  = 1'b0;
        step(2);
        // In WAIT_CLR the state is not IDLE, so busy reads 1.
        check_eq("rst_status", status, 16'h2000);
        check_eq("rst_outs", {xloc, yloc, add_img, add_fnt, rem_img, image_indx, fnt_indx},
                 32'h0);
        rst_n = 1'b1;
        step(1);

        // T1: queue while the clear is pending, then release
        bmp_sel = 1'b0; addr = BASE + 16'd2; databus = 16'h0007;
        step(1);
        addr = '0; databus = '0;
        check_eq("unsel_write", status, 16'h2000);
        bus_wr(16'd0, 16'd100);
        bus_wr(16'd1, 16'd50);
        bus_wr(16'd2, 16'h0007);
        step(4);
        check_eq("clr_hold_nostrobe", log_kind.size(), 0);
        check_eq("clr_hold_status", status, 16'h2001);
        end_clear = 1'b1;
        wait_log(1, 10, "t1_issue");
        if (log_kind.size() >= 1) begin
            check_eq("t1_kind", log_kind[0], 3'b010);
            check_eq("t1_idx", log_idx[0], 5'd3);
            check_eq("t1_xy", {log_x[0], log_y[0]}, {10'd100, 9'd50});
        end
        check_eq("t1_strobe_low", {add_img, add_fnt, rem_img}, 3'b000);
        check_eq("t1_hold", {xloc, yloc, fnt_indx}, {10'd100, 9'd50, 5'd3});
        pulse_done();
        check_eq("t1_idle_status", status, 16'h1000);

        // T2: three commands, engine replies 5 cycles after each strobe
        clear_log();
        chk_overlap = 1'b1;
        bus_wr(16'd2, 16'h0007);
        e = cyc;
        bus_wr(16'd2, 16'h000A);
        bus_wr(16'd2, 16'h800B);
        for (int k = 0; k < 3; k++) begin
            wait_log(k + 1, 40, $sformatf("t2_issue%0d", k));
            step(5);
            pulse_done();
        end
        step(2);
        chk_overlap = 1'b0;
        if (log_kind.size() == 3) begin
            check_eq("t2_latency", log_cyc[0] - e, 1);
            check_eq("t2_k0", {log_kind[0], log_idx[0]}, {3'b010, 5'd3});
            check_eq("t2_k1", {log_kind[1], log_idx[1]}, {3'b001, 5'd5});
            check_eq("t2_k2", {log_kind[2], log_idx[2]}, {3'b100, 5'd5});
        end
        check_eq("t2_status", status, 16'h1000);
        check_eq("t2_overlap", overlap_cnt, 0);
        check_eq("t2_wide", wide_cnt, 0);
        check_eq("t2_multi", multi_cnt, 0);

        // T5: stray plc_done while idle and empty
        pulse_done();
        step(3);
        check_eq("t5_nostrobe", log_kind.size(), 3);
        check_eq("t5_status", status, 16'h1000);

        // Push and pop in the same cycle at count 4
        clear_log();
        for (int i = 0; i < 5; i++) bus_wr(16'd2, 16'h0003);
        check_eq("pp_pre", status, 16'h3004);
        pulse_done();
        bus_wr(16'd2, 16'h0003);
        check_eq("pp_count", status, 16'h3004);
        check_eq("pp_strobe", add_img, 1'b1);

        // T6: reset while waiting on the engine with entries queued
        step(1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_outs", {xloc, yloc, add_img, add_fnt, rem_img, image_indx, fnt_indx},
                 32'h0);
        check_eq("t6_status_rst", status, 16'h2000);
        end_clear = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        check_eq("t6_waitclr", status, 16'h2000);
        check_eq("t6_nostrobe", log_kind.size(), 2);
        end_clear = 1'b1;
        step(3);
        check_eq("t6_flushed", status, 16'h1000);
        check_eq("t6_nostrobe2", log_kind.size(), 2);

        // T3: overflow with the engine stalled
        clear_log();
        for (int i = 1; i <= 10; i++) bus_wr(16'd2, 16'((i << 1) | 1));
        check_eq("t3_ovf", status, 16'hB008);
        check_eq("t3_issued", log_kind.size(), 1);
        if (log_kind.size() >= 1) check_eq("t3_first", {log_idx[0], log_x[0]}, {5'd1, 10'd0});
        bus_wr(16'd3, 16'h8000);
        check_eq("t3_ovf_clr", status, 16'h3008);

        // T4: timeout after 16 WAIT_DONE cycles releases the next command
        wait_log(2, 40, "t4_issue");
        if (log_kind.size() >= 2) begin
            check_eq("t4_idx", log_idx[1], 5'd2);
            check_eq("t4_spacing", log_cyc[1] - log_cyc[0], 18);
        end
        check_eq("t4_status", status, 16'h7007);
        bus_wr(16'd3, 16'h8000);
        check_eq("t4_tmo_clr", status, 16'h3007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
